// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target.
// State encoding, R/W polarity and bit-counter width.
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_WR_BYTE,
    ST_RD_BYTE,
    ST_IGNORE
  } state_e;

  localparam logic       RW_READ      = 1'b1;
  localparam logic [6:0] GENERAL_CALL = 7'h00;
  localparam int         BIT_CNT_W    = 4;

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, stable-count glitch filter and
// one-clk rise/fall pulses for one I2C line.
module i2c_line_filter #(
  parameter int FILTER_CYCLES = 3
) (
  input  logic clk,
  input  logic nreset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(FILTER_CYCLES + 1);

  logic [1:0]    sync_q;
  logic          filt_q, filt_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level flips only after FILTER_CYCLES consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
        filt_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], line_in};
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  assign level = filt_q;
  assign rise  = filt_q & ~prev_q;
  assign fall  = ~filt_q & prev_q;

endmodule

// File: rtl/i2c_target.sv
// Byte-oriented I2C target exposing a pointer-addressed
// register window with auto-increment.
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] ADDRESS       = 7'h3C,
  parameter int         PTR_BITS      = 8,
  parameter int         FILTER_CYCLES = 3
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_out,
  output logic [PTR_BITS-1:0] reg_addr,
  output logic [7:0]          reg_wdata,
  output logic                reg_wr,
  input  logic [7:0]          reg_rdata,
  output logic                reg_rd,
  output logic                busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl (
    .clk(clk), .nreset(nreset), .line_in(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda (
    .clk(clk), .nreset(nreset), .line_in(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  state_e              state_q, state_d;
  bit_cnt_t            bit_cnt_q, bit_cnt_d;
  logic [7:0]          shift_q, shift_d;
  logic                ack_q, ack_d;
  logic                rw_q, rw_d;
  logic                sda_out_q, sda_out_d;
  logic [PTR_BITS-1:0] reg_addr_q, reg_addr_d;
  logic [7:0]          reg_wdata_q, reg_wdata_d;
  logic                reg_wr_q, reg_wr_d;
  logic                reg_rd_q, reg_rd_d;
  logic                busy_q, busy_d;

  logic       start_c, stop_c, rx_last, addr_hit;
  logic [7:0] byte_in;

  assign start_c  = sda_fall & scl_lvl;
  assign stop_c   = sda_rise & scl_lvl;
  assign byte_in  = {shift_q[6:0], sda_lvl};
  assign rx_last  = scl_rise && (bit_cnt_q == bit_cnt_t'(7));
  assign addr_hit = (byte_in[7:1] == ADDRESS) &&
                    (byte_in[7:1] != GENERAL_CALL);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      ack_q       <= 1'b0;
      rw_q        <= 1'b0;
      sda_out_q   <= 1'b1;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_q    <= 1'b0;
      reg_rd_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ack_q       <= ack_d;
      rw_q        <= rw_d;
      sda_out_q   <= sda_out_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_q    <= reg_wr_d;
      reg_rd_q    <= reg_rd_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start_c) begin
      state_d = ST_ADDR;
    end else if (stop_c) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_ADDR:
          if (rx_last) state_d = addr_hit ? ST_ADDR_ACK : ST_IGNORE;
        ST_ADDR_ACK:
          if (scl_fall && ack_q)
            state_d = (rw_q == RW_READ) ? ST_RD_BYTE : ST_PTR;
        ST_PTR:
          if (scl_fall && ack_q) state_d = ST_WR_BYTE;
        ST_RD_BYTE:
          if (scl_rise && bit_cnt_q == bit_cnt_t'(8) && sda_lvl)
            state_d = ST_IGNORE;
        default: ;
      endcase
    end
  end

  // ack_q marks the ACK slot: set at the fall that pulls SDA low.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ack_d       = ack_q;
    rw_d        = rw_q;
    sda_out_d   = sda_out_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_d    = 1'b0;
    reg_rd_d    = 1'b0;
    busy_d      = busy_q;
    if (start_c || stop_c) begin
      bit_cnt_d = '0;
      ack_d     = 1'b0;
      sda_out_d = 1'b1;
      if (stop_c) busy_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: if (scl_rise) begin
          shift_d   = byte_in;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (rx_last) begin
            bit_cnt_d = '0;
            rw_d      = sda_lvl;
            busy_d    = addr_hit;
          end
        end
        ST_ADDR_ACK: if (scl_fall) begin
          if (!ack_q) begin
            ack_d     = 1'b1;
            sda_out_d = 1'b0;
          end else begin
            ack_d     = 1'b0;
            bit_cnt_d = '0;
            sda_out_d = 1'b1;
            if (rw_q == RW_READ) begin
              shift_d   = reg_rdata;
              reg_rd_d  = 1'b1;
              sda_out_d = reg_rdata[7];
            end
          end
        end
        ST_PTR, ST_WR_BYTE: begin
          if (scl_rise && bit_cnt_q < bit_cnt_t'(8)) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (rx_last) begin
              if (state_q == ST_PTR) begin
                reg_addr_d = PTR_BITS'(byte_in);
              end else begin
                reg_wdata_d = byte_in;
                reg_wr_d    = 1'b1;
              end
            end
          end
          if (scl_fall && bit_cnt_q == bit_cnt_t'(8)) begin
            if (!ack_q) begin
              ack_d     = 1'b1;
              sda_out_d = 1'b0;
            end else begin
              ack_d     = 1'b0;
              sda_out_d = 1'b1;
              bit_cnt_d = '0;
              if (state_q == ST_WR_BYTE) reg_addr_d = reg_addr_q + 1'b1;
            end
          end
        end
        // bit_cnt 8 = master ACK slot, 9 = reload on next fall.
        ST_RD_BYTE: begin
          if (scl_rise) begin
            if (bit_cnt_q < bit_cnt_t'(8)) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end else if (bit_cnt_q == bit_cnt_t'(8)) begin
              if (!sda_lvl) begin
                reg_addr_d = reg_addr_q + 1'b1;
                bit_cnt_d  = bit_cnt_t'(9);
              end else begin
                busy_d = 1'b0;
              end
            end
          end
          if (scl_fall) begin
            if (bit_cnt_q == bit_cnt_t'(9)) begin
              shift_d   = reg_rdata;
              reg_rd_d  = 1'b1;
              sda_out_d = reg_rdata[7];
              bit_cnt_d = '0;
            end else if (bit_cnt_q == bit_cnt_t'(8)) begin
              sda_out_d = 1'b1;
            end else if (bit_cnt_q != '0) begin
              sda_out_d = shift_q[6];
              shift_d   = {shift_q[6:0], 1'b0};
            end
          end
        end
        default: sda_out_d = 1'b1;
      endcase
    end
  end

  assign sda_out   = sda_out_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr    = reg_wr_q;
  assign reg_rd    = reg_rd_q;
  assign busy      = busy_q;

endmodule
